// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// -----------------------------------------------------------------------------
// Schedules host commands into the LCD image-processing engine. Host opcodes
// are buffered in a DEPTH-entry FIFO and issued one at a time on lcd_cmd /
// lcd_cmd_valid whenever the engine reports lcd_busy low. Opcodes 12..15 are
// dropped and counted. Issuing opcode 0 (write image) ends the frame: the
// sequencer waits for lcd_done, pulses frame_done and then parks in FINISH
// until reset.
//
// Optional feature: define LCD_SEQ_AUTO_WRITE_EN to let the sequencer issue
// opcode 0 on its own after AW_TIMEOUT idle cycles (FIFO empty, engine idle,
// at least one command already issued).
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   host_cmd       opcode to enqueue        host_push   enqueue strobe
//   host_full      FIFO full (registered)   host_count  FIFO occupancy
//   overflow       sticky push-while-full flag
//   lcd_cmd        opcode to engine         lcd_cmd_valid  one-cycle strobe
//   lcd_busy       engine busy              lcd_done       engine finished
//   frame_done     one-cycle completion pulse
//   drop_cnt       saturating count of dropped opcodes
//   issue_cnt      wrapping count of issued opcodes
// -----------------------------------------------------------------------------
module lcd_cmd_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               host_cmd,
  input  logic                     host_push,
  output logic                     host_full,
  output logic [$clog2(DEPTH):0]   host_count,
  output logic                     overflow,
  output logic [3:0]               lcd_cmd,
  output logic                     lcd_cmd_valid,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic                     frame_done,
  output logic [7:0]               drop_cnt,
  output logic [15:0]              issue_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {READY, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t        state, state_next;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_next;
  logic          push_ok, empty, head_illegal;
  logic [3:0]    head;
  logic          pop, do_issue, do_drop, aw_fire;
  logic [3:0]    issue_op;

  assign push_ok      = host_push && !host_full;
  assign empty        = (host_count == CW'(0));
  assign head         = mem[rd_ptr];
  assign head_illegal = (head[3:2] == 2'b11);

`ifdef LCD_SEQ_AUTO_WRITE_EN
  localparam int IW = $clog2(AW_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          issued_any, aw_qual;

  // Idle qualifies only in READY with nothing queued and the engine free,
  // and only once the frame has actually started.
  assign aw_qual = (state == READY) && empty && !lcd_busy && issued_any;
  assign aw_fire = aw_qual && (idle_cnt == IW'(AW_TIMEOUT - 1));

  // Idle counter: cleared by any push or issue, otherwise counts idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt   <= '0;
      issued_any <= 1'b0;
    end else begin
      if (do_issue) issued_any <= 1'b1;
      if (push_ok || do_issue) idle_cnt <= '0;
      else if (aw_qual && idle_cnt != IW'(AW_TIMEOUT)) idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign aw_fire = 1'b0;
`endif

  // Next-state and per-cycle FIFO/issue decisions.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    do_issue   = 1'b0;
    do_drop    = 1'b0;
    issue_op   = head;
    case (state)
      READY: begin
        if (!empty) begin
          if (head_illegal) begin
            pop     = 1'b1;
            do_drop = 1'b1;
          end else if (!lcd_busy) begin
            pop        = 1'b1;
            do_issue   = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = READY;
          end
        end else if (aw_fire) begin
          do_issue   = 1'b1;
          issue_op   = 4'd0;
          state_next = ISSUE;
        end else begin
          state_next = READY;
        end
      end
      // lcd_cmd still holds the opcode being strobed this cycle.
      ISSUE:     state_next = (lcd_cmd == 4'd0) ? WAIT_DONE : READY;
      WAIT_DONE: state_next = lcd_done ? FINISH : WAIT_DONE;
      FINISH:    state_next = FINISH;
      default:   state_next = READY;
    endcase
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = host_count;
    if (push_ok && !pop)      count_next = host_count + CW'(1);
    else if (!push_ok && pop) count_next = host_count - CW'(1);
    else                      count_next = host_count;
  end

  // FIFO storage; contents are discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= host_cmd;
  end

  // State register, FIFO bookkeeping, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= READY;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      host_count    <= '0;
      host_full     <= 1'b0;
      overflow      <= 1'b0;
      lcd_cmd       <= 4'd0;
      lcd_cmd_valid <= 1'b0;
      frame_done    <= 1'b0;
      drop_cnt      <= 8'd0;
      issue_cnt     <= 16'd0;
    end else begin
      state      <= state_next;
      host_count <= count_next;
      host_full  <= (count_next == CW'(DEPTH));
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (host_push && host_full) overflow <= 1'b1;
      if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (do_issue) begin
        lcd_cmd   <= issue_op;
        issue_cnt <= issue_cnt + 16'd1;
      end
      lcd_cmd_valid <= do_issue;
      frame_done    <= (state == WAIT_DONE) && lcd_done;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed testbench for lcd_cmd_sequencer (DEPTH=8, AW_TIMEOUT=16).
// Cycle k of a scenario is the clock period that starts with the k-th rising
// edge after the scenario's reset release; inputs are driven and outputs
// sampled 1 time unit after that edge.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_push = 1'b0;
  logic       host_full;
  logic [3:0] host_count;
  logic       overflow;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b0;
  logic       lcd_done = 1'b0;
  logic       frame_done;
  logic [7:0] drop_cnt;
  logic [15:0] issue_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] strobes [$];
  int frames = 0;

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .AW_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_push(host_push),
    .host_full(host_full), .host_count(host_count), .overflow(overflow),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .frame_done(frame_done), .drop_cnt(drop_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Record every issued opcode and every frame_done pulse.
  always @(posedge clk) begin
    if (lcd_cmd_valid) strobes.push_back(lcd_cmd);
    if (frame_done) frames = frames + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; host_push = 1'b0; host_cmd = 4'd0;
    lcd_busy = 1'b0; lcd_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    strobes.delete();
    frames = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({lcd_cmd, lcd_cmd_valid, frame_done, host_full, host_count, overflow, drop_cnt, issue_cnt}
        !== {4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_values: got cmd=%0d v=%0b fd=%0b full=%0b cnt=%0d ovf=%0b drop=%0d iss=%0d expected all zero",
               lcd_cmd, lcd_cmd_valid, frame_done, host_full, host_count, overflow, drop_cnt, issue_cnt);
    end
  endtask

  // Push 3,5,0 back to back; lcd_done early (ignored) and at cycle 10.
  task automatic test_basic();
    logic exp_v;
    logic [3:0] exp_c;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      exp_v = (k == 2 || k == 4 || k == 6);
      exp_c = (k == 2) ? 4'd3 : (k == 4) ? 4'd5 : 4'd0;
      n_vec++;
      if (lcd_cmd_valid !== exp_v) begin
        n_err++;
        $display("FAIL basic_valid cycle %0d: got %0b expected %0b", k, lcd_cmd_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (lcd_cmd !== exp_c) begin
          n_err++;
          $display("FAIL basic_cmd cycle %0d: got %0d expected %0d", k, lcd_cmd, exp_c);
        end
      end
      n_vec++;
      if (frame_done !== (k == 11)) begin
        n_err++;
        $display("FAIL basic_frame_done cycle %0d: got %0b expected %0b", k, frame_done, (k == 11));
      end
      host_push = (k <= 2);
      host_cmd  = (k == 0) ? 4'd3 : (k == 1) ? 4'd5 : 4'd0;
      lcd_done  = (k == 1 || k == 10);
      tick();
    end
    n_vec++;
    if (issue_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL basic_issue_cnt: got %0d expected 3", issue_cnt);
    end
  endtask

  // Busy holds opcode 4 in the FIFO; busy drops at cycle 6, strobe at 7.
  task automatic test_busy();
    do_reset();
    lcd_busy = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      n_vec++;
      if (lcd_cmd_valid !== (k == 7)) begin
        n_err++;
        $display("FAIL busy_valid cycle %0d: got %0b expected %0b", k, lcd_cmd_valid, (k == 7));
      end
      host_push = (k == 0);
      host_cmd  = 4'd4;
      if (k == 6) lcd_busy = 1'b0;
      tick();
    end
    n_vec++;
    if (strobes.size() != 1 || strobes[0] !== 4'd4) begin
      n_err++;
      $display("FAIL busy_cmd: got %0d strobes first=%0d expected 1 strobe of 4",
               strobes.size(), (strobes.size() > 0) ? strobes[0] : 4'd0);
    end
  endtask

  // 13 and 15 are dropped (one cycle each), 7 issues at cycle 4.
  task automatic test_drop();
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      n_vec++;
      if (lcd_cmd_valid !== (k == 4)) begin
        n_err++;
        $display("FAIL drop_valid cycle %0d: got %0b expected %0b", k, lcd_cmd_valid, (k == 4));
      end
      host_push = (k <= 2);
      host_cmd  = (k == 0) ? 4'd13 : (k == 1) ? 4'd15 : 4'd7;
      tick();
    end
    n_vec++;
    if (drop_cnt !== 8'd2 || issue_cnt !== 16'd1 || strobes.size() != 1 || strobes[0] !== 4'd7) begin
      n_err++;
      $display("FAIL drop_counts: got drop=%0d issue=%0d strobes=%0d expected drop=2 issue=1 strobes=1 cmd 7",
               drop_cnt, issue_cnt, strobes.size());
    end
  endtask

  // Ten pushes (1..10) while busy: only 1..8 accepted, overflow set.
  task automatic test_overflow();
    do_reset();
    lcd_busy = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k == 7 || k == 8) begin
        n_vec++;
        if (host_full !== (k == 8)) begin
          n_err++;
          $display("FAIL ovf_full cycle %0d: got %0b expected %0b", k, host_full, (k == 8));
        end
      end
      host_push = 1'b1;
      host_cmd  = 4'(k + 1);
      tick();
    end
    host_push = 1'b0;
    n_vec++;
    if (host_full !== 1'b1 || overflow !== 1'b1 || host_count !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_state: got full=%0b ovf=%0b cnt=%0d expected 1 1 8", host_full, overflow, host_count);
    end
    lcd_busy = 1'b0;
    for (int k = 0; k < 24; k++) tick();
    n_vec++;
    if (strobes.size() != DEPTH) begin
      n_err++;
      $display("FAIL ovf_issue_count: got %0d expected %0d", strobes.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < strobes.size(); i++) begin
      n_vec++;
      if (strobes[i] !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL ovf_order idx %0d: got %0d expected %0d", i, strobes[i], i + 1);
      end
    end
  endtask

  // After the frame completes, pushes are accepted but nothing issues.
  task automatic test_finish();
    do_reset();
    for (int k = 0; k <= 14; k++) begin
      host_push = (k == 0 || k == 6);
      host_cmd  = (k == 0) ? 4'd0 : 4'd2;
      lcd_done  = (k == 4);
      tick();
    end
    n_vec++;
    if (strobes.size() != 1 || frames != 1 || host_count !== 4'd1) begin
      n_err++;
      $display("FAIL finish_frozen: got strobes=%0d frames=%0d cnt=%0d expected 1 1 1",
               strobes.size(), frames, host_count);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if ({lcd_cmd_valid, frame_done, host_full, host_count, overflow, drop_cnt, issue_cnt, lcd_cmd}
        !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 16'd0, 4'd0}) begin
      n_err++;
      $display("FAIL finish_reset: got v=%0b cnt=%0d iss=%0d cmd=%0d expected zeros",
               lcd_cmd_valid, host_count, issue_cnt, lcd_cmd);
    end
    reset = 1'b0;
  endtask

  // One command then idle: auto-write fires at cycle 19 only with the macro.
  task automatic test_autowrite();
    logic exp_v;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
`ifdef LCD_SEQ_AUTO_WRITE_EN
      exp_v = (k == 2 || k == 19);
`else
      exp_v = (k == 2);
`endif
      n_vec++;
      if (lcd_cmd_valid !== exp_v) begin
        n_err++;
        $display("FAIL autowrite_valid cycle %0d: got %0b expected %0b", k, lcd_cmd_valid, exp_v);
      end
      if (k == 19 && exp_v) begin
        n_vec++;
        if (lcd_cmd !== 4'd0) begin
          n_err++;
          $display("FAIL autowrite_cmd: got %0d expected 0", lcd_cmd);
        end
      end
      host_push = (k == 0);
      host_cmd  = 4'd1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_drop();
    test_overflow();
    test_finish();
    test_autowrite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
